// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// One bit per cycle. Divide-by-zero and signed overflow finish straight from IDLE.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [4:0]      wr_reg_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      wr_reg_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r, state_n;
  logic [5:0]  cnt_r;
  logic [2:0]  funct3_r;
  logic [4:0]  wr_reg_lat_r;
  logic        neg_a_r, neg_b_r;
  logic [31:0] opnd_r;
  // Multiply: running product. Divide: {remainder, quotient/dividend}.
  logic [63:0] acc_r;

  logic        sign_a_s, sign_b_s, neg_a_s, neg_b_s;
  logic [31:0] a_mag_s, b_mag_s;
  logic        div_zero_s, div_ovf_s, early_s;
  logic [31:0] early_res_s;
  logic [32:0] mul_sum_s, div_shift_s;
  logic [33:0] div_diff_s;
  logic [63:0] step_s, prod_s;
  logic [31:0] quo_s, rem_s, final_res_s, res_n;
  logic        accept_s, load_res_s;
  logic [4:0]  wr_n;

  assign accept_s = (state_r == IDLE) && start_i && !flush_i;
  assign busy_o   = accept_s || (state_r == CALC);
  assign done_o   = (state_r == DONE) && !flush_i;

  // Operand signs and magnitudes, plus early-exit detection.
  always_comb begin
    sign_a_s    = (funct3_i == 3'd1) || (funct3_i == 3'd2) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
    sign_b_s    = (funct3_i == 3'd1) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
    neg_a_s     = sign_a_s && op_a_i[31];
    neg_b_s     = sign_b_s && op_b_i[31];
    a_mag_s     = neg_a_s ? (32'd0 - op_a_i) : op_a_i;
    b_mag_s     = neg_b_s ? (32'd0 - op_b_i) : op_b_i;
    div_zero_s  = funct3_i[2] && (op_b_i == 32'd0);
    div_ovf_s   = funct3_i[2] && !funct3_i[0] && (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);
    early_s     = div_zero_s || div_ovf_s;
    if (div_zero_s) begin
      early_res_s = funct3_i[1] ? op_a_i : 32'hFFFF_FFFF;
    end else begin
      early_res_s = funct3_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One shift-add or restoring-divide step, and the sign-corrected result.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
    div_shift_s = {acc_r[63:32], acc_r[31]};
    div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_r};
    if (funct3_r[2]) begin
      step_s = {(div_diff_s[33] ? div_shift_s[31:0] : div_diff_s[31:0]), acc_r[30:0], ~div_diff_s[33]};
    end else begin
      step_s = {mul_sum_s, acc_r[31:1]};
    end
    prod_s = (neg_a_r ^ neg_b_r) ? (64'd0 - step_s) : step_s;
    quo_s  = (neg_a_r ^ neg_b_r) ? (32'd0 - step_s[31:0]) : step_s[31:0];
    rem_s  = neg_a_r ? (32'd0 - step_s[63:32]) : step_s[63:32];
    case (funct3_r)
      3'd0:                final_res_s = prod_s[31:0];
      3'd1, 3'd2, 3'd3:    final_res_s = prod_s[63:32];
      3'd4, 3'd5:          final_res_s = quo_s;
      3'd6, 3'd7:          final_res_s = rem_s;
      default:             final_res_s = 32'd0;
    endcase
  end

  // Next-state logic and result-load decision.
  always_comb begin
    state_n    = state_r;
    load_res_s = 1'b0;
    res_n      = final_res_s;
    wr_n       = wr_reg_lat_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (early_s) begin
            state_n    = DONE;
            load_res_s = 1'b1;
            res_n      = early_res_s;
            wr_n       = wr_reg_i;
          end else begin
            state_n = CALC;
          end
        end else begin
          state_n = IDLE;
        end
      end
      CALC: begin
        if (flush_i) begin
          state_n = IDLE;
        end else if (cnt_r == 6'd31) begin
          state_n    = DONE;
          load_res_s = 1'b1;
        end else begin
          state_n = CALC;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 6'd0;
      funct3_r     <= 3'd0;
      wr_reg_lat_r <= 5'd0;
      neg_a_r      <= 1'b0;
      neg_b_r      <= 1'b0;
      opnd_r       <= 32'd0;
      acc_r        <= 64'd0;
      result_o     <= 32'd0;
      wr_reg_o     <= 5'd0;
    end else begin
      state_r <= state_n;
      if (accept_s) begin
        funct3_r     <= funct3_i;
        wr_reg_lat_r <= wr_reg_i;
        neg_a_r      <= neg_a_s;
        neg_b_r      <= neg_b_s;
        cnt_r        <= 6'd0;
        // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
        opnd_r       <= funct3_i[2] ? b_mag_s : a_mag_s;
        acc_r        <= funct3_i[2] ? {32'd0, a_mag_s} : {32'd0, b_mag_s};
      end else if (state_r == CALC) begin
        acc_r <= step_s;
        cnt_r <= cnt_r + 6'd1;
      end
      if (load_res_s) begin
        result_o <= res_n;
        wr_reg_o <= wr_n;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases, flush/reset aborts,
// back-to-back issue and random operations against an arithmetic reference.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i, op_b_i;
  logic [4:0]  wr_reg_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  wr_reg_o;

  int n_checks = 0;
  int n_pass   = 0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .flush_i(flush_i),
    .funct3_i(funct3_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .wr_reg_i(wr_reg_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .wr_reg_o(wr_reg_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got no summary, required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // RV32M semantics straight from the ISA rules using 64-bit integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_early(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    funct3_i = f; op_a_i = a; op_b_i = b; wr_reg_i = rd; start_i = 1'b1;
  endtask

  // Called in the start cycle just after driving; returns inside the DONE cycle.
  task automatic wait_done(input string tag, input bit keep, input int exp_lat,
                           input logic [31:0] exp_res, input logic [4:0] exp_rd);
    int cyc = 0;
    int busy_n = 0;
    bit got = 1'b0;
    while (!got && cyc < 100) begin
      #1;
      if (busy_o) busy_n++;
      if (done_o) got = 1'b1;
      else begin
        @(negedge clk);
        if (!keep) begin
          start_i = 1'b0; op_a_i = $urandom; op_b_i = $urandom; funct3_i = 3'($urandom);
        end
        cyc++;
      end
    end
    check_eq({tag, "_done"}, 32'(got), 32'd1);
    check_eq({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check_eq({tag, "_busy"}, 32'(busy_n), 32'(exp_lat));
    check_eq({tag, "_res"}, result_o, exp_res);
    check_eq({tag, "_rd"}, 32'(wr_reg_o), 32'(exp_rd));
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    drive(f, a, b, rd);
    wait_done(tag, 1'b0, is_early(f, a, b) ? 1 : 33, ref_result(f, a, b), rd);
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check_eq({tag, "_pulse"}, 32'(done_o), 32'd0);
  endtask

  logic [31:0] prev_res;
  logic [4:0]  prev_rd;
  int          n_done;

  initial begin
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = 3'd0; op_a_i = 32'd0; op_b_i = 32'd0; wr_reg_i = 5'd0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_res", result_o, 32'd0);
    check_eq("rst_rd", 32'(wr_reg_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_7x-3", 3'd0, 32'h7, 32'hFFFF_FFFD, 5'd1);
    check_eq("mul_known", result_o, 32'hFFFF_FFEB);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2);
    check_eq("mulh_known", result_o, 32'h0000_0000);
    run_op("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
    check_eq("mulhsu_known", result_o, 32'h8000_0000);
    run_op("mulhu", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    check_eq("mulhu_known", result_o, 32'h7FFF_FFFF);
    run_op("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5);
    check_eq("div_known", result_o, 32'hFFFF_FFFD);
    run_op("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
    check_eq("rem_known", result_o, 32'hFFFF_FFFF);
    run_op("divu", 3'd5, 32'hFFFF_FFFF, 32'h10, 5'd7);
    check_eq("divu_known", result_o, 32'h0FFF_FFFF);
    run_op("remu", 3'd7, 32'd100, 32'd7, 5'd8);
    check_eq("remu_known", result_o, 32'd2);
    run_op("div_by0", 3'd4, 32'd5, 32'd0, 5'd10);
    check_eq("div_by0_known", result_o, 32'hFFFF_FFFF);
    run_op("remu_by0", 3'd7, 32'd5, 32'd0, 5'd11);
    check_eq("remu_by0_known", result_o, 32'd5);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    check_eq("div_ovf_known", result_o, 32'h8000_0000);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    check_eq("rem_ovf_known", result_o, 32'd0);

    // Flush at counter 10: no completion, outputs untouched.
    run_op("pre_flush", 3'd0, 32'd3, 32'd5, 5'd14);
    prev_res = result_o; prev_rd = wr_reg_o;
    @(negedge clk);
    drive(3'd4, 32'd1000, 32'd7, 5'd20);
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1;
    check_eq("flush_busy_calc", 32'(busy_o), 32'd1);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check_eq("flush_idle_busy", 32'(busy_o), 32'd0);
    n_done = 0;
    repeat (40) begin @(negedge clk); #1; if (done_o) n_done++; end
    check_eq("flush_no_done", 32'(n_done), 32'd0);
    check_eq("flush_res_kept", result_o, prev_res);
    check_eq("flush_rd_kept", 32'(wr_reg_o), 32'(prev_rd));

    // Flush together with start: nothing is accepted.
    @(negedge clk);
    drive(3'd0, 32'd9, 32'd9, 5'd21);
    flush_i = 1'b1;
    #1;
    check_eq("flush_start_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    check_eq("flush_start_idle", 32'(busy_o), 32'd0);
    check_eq("flush_start_res", result_o, prev_res);

    // Asynchronous reset mid-CALC clears everything.
    @(negedge clk);
    drive(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd22);
    @(negedge clk);
    start_i = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy_o), 32'd0);
    check_eq("arst_done", 32'(done_o), 32'd0);
    check_eq("arst_res", result_o, 32'd0);
    check_eq("arst_rd", 32'(wr_reg_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (40) begin @(negedge clk); #1; if (done_o) n_done++; end
    check_eq("arst_no_done", 32'(n_done), 32'd0);

    // Back-to-back with start held through DONE.
    @(negedge clk);
    drive(3'd5, 32'd9, 32'd3, 5'd5);
    wait_done("b2b_divu", 1'b1, 33, 32'd3, 5'd5);
    drive(3'd0, 32'd6, 32'd7, 5'd9);
    #1;
    check_eq("b2b_done_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    wait_done("b2b_mul", 1'b0, 33, 32'd42, 5'd9);
    @(negedge clk);
    start_i = 1'b0;

    // Random operations, with zero and overflow corners mixed in.
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, 5'($urandom_range(1, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
